mem_req_port: RTL and testbench

Initiator for one memblk port. It accepts line read and write requests from a core-side valid/ready interface and drives one memblk read/write port lane. It tracks reads in flight through the fixed memblk pipeline and hands returned lines back in order on a backpressurable response interface. One instance is used per memblk port (36 per memblk).

---
 rtl/mem_req_port_pkg.sv | 26 ++
 rtl/mem_req_port_if.sv | 36 +++
 rtl/mem_req_port_fifo.sv | 59 +++++
 rtl/mem_req_port.sv | 167 ++++++++++++++++
 tb/tb_mem_req_port.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_port_pkg.sv
// mem_pkg: shared widths, address field positions and line type for the
// memblk request port.
//   LINE_W  - one memblk line: {5-bit state, 8 x 66-bit words}
//   ADDR_W  - memblk address: [37]=read-for-own, [36:4]=line, [3:0]=xdata
//   MEM_LAT - memblk pipeline depth (rden_in to rden_out, non-stalled cycles)
package mem_pkg;

  localparam int LINE_W       = 533;
  localparam int ADDR_W       = 39;
  localparam int MEM_LAT      = 48;

  localparam int ADDR_RFO     = 37;
  localparam int ADDR_LINE_HI = 36;
  localparam int ADDR_LINE_LO = 4;
  localparam int XDATA_W      = 4;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_LINE_HI-ADDR_LINE_LO:0] line_addr_t;

  // Line-address field of a full memblk address.
  function automatic line_addr_t line_addr(input addr_t a);
    return a[ADDR_LINE_HI:ADDR_LINE_LO];
  endfunction

endpackage

// File: rtl/mem_req_port_if.sv
// mem_req_port_if: core-side request/response handshake of one memblk port.
//   req_valid/req_ready  request handshake (accepted when both high at posedge)
//   req_we               1 = write line, 0 = read line
//   req_addr, req_wdata  address and write line
//   req_tag              tag returned with the read response
//   resp_valid/ready     response handshake (consumed when both high)
//   resp_data, resp_tag  returned line and its tag
// master: the core issuing requests.  slave: the mem_req_port.
interface mem_req_port_if #(
  parameter int TAG_W = 4
);
  import mem_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  addr_t            req_addr;
  line_t            req_wdata;
  logic [TAG_W-1:0] req_tag;

  logic             resp_valid;
  logic             resp_ready;
  line_t            resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );

endinterface

// File: rtl/mem_req_port_fifo.sv
// mem_req_fifo: synchronous show-ahead FIFO with asynchronous reset.
//   clk, rst        clock, async active-high reset (empties the FIFO)
//   push, wr_data   write when push and not full
//   pop             drop the head when pop and not empty
//   rd_data         current head (valid when !empty)
//   empty, full     status flags
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate counter. DEPTH must be a power of two, at least 2.
module mem_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_arr [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_arr[rd_ptr_reg[AW-1:0]];

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_arr[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/mem_req_port.sv
// mem_req_port: initiator for one memblk read/write port lane.
//   clk, rst          clock, async active-high reset
//   core              core-side request/response (mem_req_port_if.slave)
//   mem_stall         memblk global stall
//   mem_rdaddr0/rden  read lane to memblk
//   mem_wraddr0/wrdata/wren  write lane to memblk
//   mem_rddata/rden_out      read return lane from memblk
//   err               sticky: a read return arrived with nothing outstanding
// A one-entry issue register feeds the memblk lane. Read tags wait in a tag
// FIFO while the read travels the fixed memblk pipeline; each return is paired
// with its tag and queued in a response FIFO. Because memblk cannot be
// backpressured per lane, reads are admitted only against credits that count
// every read not yet handed to the core, so the response FIFO cannot overflow.
module mem_req_port
  import mem_pkg::*;
#(
  parameter int LAT   = MEM_LAT,
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_req_port_if.slave       core,
  input  logic                mem_stall,
  output addr_t               mem_rdaddr0,
  output logic                mem_rden,
  output addr_t               mem_wraddr0,
  output line_t               mem_wrdata,
  output logic                mem_wren,
  input  line_t               mem_rddata,
  input  logic                mem_rden_out,
  output logic                err
);

  if (LAT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("mem_req_port: LAT must be >= 1 and DEPTH a power of two >= 2");
  end

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  localparam int                CRED_W   = $clog2(DEPTH + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(DEPTH);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

  localparam int RESP_W = TAG_W + LINE_W;

  logic [0:0]        state_reg;
  logic [CRED_W-1:0] credits_reg;
  logic              err_reg;

  logic              req_ready_int;
  logic              read_room;
  logic              accept;
  logic              rd_accept;
  logic              ret;
  logic              resp_pop;

  logic [TAG_W-1:0]  tag_head;
  logic              tag_empty;
  logic              tag_full;
  logic [RESP_W-1:0] resp_head;
  logic              resp_empty;
  logic              resp_full;

  // A read may enter when a credit is free, or when a response leaves on the
  // same edge (credit count then stays put). The FIFO-full terms are implied
  // by the credit count and only act as a backstop.
  assign read_room = ((credits_reg < CRED_MAX) || resp_pop) &&
                     !tag_full && (!resp_full || resp_pop);

  // The issue register can take a new request when empty, or when held and
  // draining into memblk on this edge.
  assign req_ready_int = ((state_reg == ST_EMPTY) || !mem_stall) &&
                         (core.req_we || read_room);

  assign core.req_ready = req_ready_int;
  assign accept         = core.req_valid && req_ready_int;
  assign rd_accept      = accept && !core.req_we;

  // A return is only real on a non-stalled edge.
  assign ret      = mem_rden_out && !mem_stall;
  assign resp_pop = !resp_empty && core.resp_ready;

  // Issue register. Address/data fields of the lane not being used keep
  // their previous value; only the enables tell memblk what is live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_EMPTY;
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
      mem_rdaddr0 <= '0;
      mem_wraddr0 <= '0;
      mem_wrdata  <= '0;
    end else if (accept) begin
      state_reg <= ST_HELD;
      if (core.req_we) begin
        mem_wren    <= 1'b1;
        mem_rden    <= 1'b0;
        mem_wraddr0 <= core.req_addr;
        mem_wrdata  <= core.req_wdata;
      end else begin
        mem_rden    <= 1'b1;
        mem_wren    <= 1'b0;
        mem_rdaddr0 <= core.req_addr;
      end
    end else if ((state_reg == ST_HELD) && !mem_stall) begin
      state_reg <= ST_EMPTY;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
    end
  end

  // Credits: reads accepted and not yet consumed by the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_reg <= '0;
    end else if (rd_accept && !resp_pop) begin
      credits_reg <= credits_reg + CRED_ONE;
    end else if (!rd_accept && resp_pop) begin
      credits_reg <= credits_reg - CRED_ONE;
    end
  end

  // A return with no tag waiting has no owner: flag it and drop the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (ret && tag_empty) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;

  mem_req_fifo #(
    .W     (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rd_accept),
    .wr_data (core.req_tag),
    .pop     (ret),
    .rd_data (tag_head),
    .empty   (tag_empty),
    .full    (tag_full)
  );

  mem_req_fifo #(
    .W     (RESP_W),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (ret && !tag_empty),
    .wr_data ({tag_head, mem_rddata}),
    .pop     (resp_pop),
    .rd_data (resp_head),
    .empty   (resp_empty),
    .full    (resp_full)
  );

  assign core.resp_valid = !resp_empty;
  assign {core.resp_tag, core.resp_data} = resp_head;

endmodule

// File: tb/tb_mem_req_port.sv
// tb_mem_req_port: drives mem_req_port against a behavioural memblk lane
// (LAT-deep pipeline frozen by mem_stall, line memory written on issue) and
// checks returned lines against a scoreboard filled at read accept.
module tb_mem_req_port;
  import mem_pkg::*;

  localparam int LAT   = 48;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    line_t            data;
  } exp_t;

  logic  clk;
  logic  rst;
  logic  mem_stall;
  addr_t mem_rdaddr0;
  logic  mem_rden;
  addr_t mem_wraddr0;
  line_t mem_wrdata;
  logic  mem_wren;
  line_t mem_rddata;
  logic  mem_rden_out;
  logic  err;
  logic  force_ret;

  int    n_checks;
  int    n_fail;
  int    cyc;

  exp_t  sb_q[$];
  exp_t  mon_e;
  line_t shadow [line_addr_t];
  line_t mem_model [line_addr_t];

  logic [LAT:1] pipe_v;
  line_t        pipe_d [1:LAT];

  mem_req_port_if #(.TAG_W(TAG_W)) bus ();

  mem_req_port #(
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .core         (bus),
    .mem_stall    (mem_stall),
    .mem_rdaddr0  (mem_rdaddr0),
    .mem_rden     (mem_rden),
    .mem_wraddr0  (mem_wraddr0),
    .mem_wrdata   (mem_wrdata),
    .mem_wren     (mem_wren),
    .mem_rddata   (mem_rddata),
    .mem_rden_out (mem_rden_out),
    .err          (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic line_t dflt_line(input addr_t a);
    return line_t'({a, a, 8'h5A});
  endfunction

  function automatic line_t mkline(input int seed);
    logic [543:0] t;
    for (int i = 0; i < 17; i++) begin
      t[i*32 +: 32] = 32'(seed) * 32'h9E3779B1 + 32'(i) * 32'h01234567;
    end
    return t[LINE_W-1:0];
  endfunction

  function automatic line_t model_read(input addr_t a);
    if (mem_model.exists(line_addr(a))) return mem_model[line_addr(a)];
    return dflt_line(a);
  endfunction

  function automatic line_t expect_read(input addr_t a);
    if (shadow.exists(line_addr(a))) return shadow[line_addr(a)];
    return dflt_line(a);
  endfunction

  // memblk lane model; shares the reset so in-flight reads vanish with it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
    end else if (!mem_stall) begin
      pipe_v    <= {pipe_v[LAT-1:1], mem_rden};
      pipe_d[1] <= model_read(mem_rdaddr0);
      for (int i = 2; i <= LAT; i++) pipe_d[i] <= pipe_d[i-1];
      if (mem_wren) mem_model[line_addr(mem_wraddr0)] = mem_wrdata;
    end
  end

  assign mem_rden_out = pipe_v[LAT] | force_ret;
  assign mem_rddata   = pipe_d[LAT];

  // Scoreboard: every consumed response is compared with the oldest read.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got tag %0d data[63:0]=%h, required no response",
                 bus.resp_tag, bus.resp_data[63:0]);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.resp_tag !== mon_e.tag || bus.resp_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL resp_data: got tag %0d data[63:0]=%h, required tag %0d data[63:0]=%h",
                   bus.resp_tag, bus.resp_data[63:0], mon_e.tag, mon_e.data[63:0]);
        end else begin
          $display("resp tag %0d data[63:0]=%h ok at cycle %0d", bus.resp_tag,
                   bus.resp_data[63:0], cyc);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic we, input addr_t addr, input line_t data,
                      input logic [TAG_W-1:0] tag, output int acc);
    int   n;
    exp_t e;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    bus.req_tag   = tag;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: req_ready=%0b after %0d cycles, required 1", bus.req_ready, n);
      acc = -1;
    end else begin
      acc = cyc + 1;
      if (we) begin
        shadow[line_addr(addr)] = data;
      end else begin
        e.tag  = tag;
        e.data = expect_read(addr);
        sb_q.push_back(e);
      end
      $display("req we=%0b addr=%h tag=%0d accepted at edge %0d", we, addr, tag, acc);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    force_ret = 1'b0;
    mem_stall = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_tag = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (mem_rden !== 1'b0 || mem_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_enables: rden=%0b wren=%0b, required 0 0", mem_rden, mem_wren);
    end
    n_checks++;
    if (mem_rdaddr0 !== '0 || mem_wraddr0 !== '0 || mem_wrdata !== '0) begin
      n_fail++;
      $display("FAIL reset_lane: rdaddr=%h wraddr=%h wrdata[63:0]=%h, required 0",
               mem_rdaddr0, mem_wraddr0, mem_wrdata[63:0]);
    end
    n_checks++;
    if (bus.resp_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: resp_valid=%0b err=%0b, required 0 0", bus.resp_valid, err);
    end
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: req_ready=%0b, required 1", bus.req_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input int acc, input int lat, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.resp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!bus.resp_valid || (cyc - acc) != lat) begin
      n_fail++;
      $display("FAIL %s: resp_valid=%0b latency=%0d edges, required 1 and %0d",
               name, bus.resp_valid, cyc - acc, lat);
    end else begin
      $display("%s: latency %0d edges", name, cyc - acc);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.resp_ready = 1'b1;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0 || bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: %0d responses missing, resp_valid=%0b, required 0 and 0",
               sb_q.size(), bus.resp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int    acc;
    line_t a;
    addr_t addr;
    a = mkline(1);
    addr = 39'h0_0000_0100;
    bus.resp_ready = 1'b1;
    send(1'b1, addr, a, 4'd0, acc);
    n_checks++;
    if (mem_wren !== 1'b1 || mem_rden !== 1'b0 || mem_wraddr0 !== addr || mem_wrdata !== a) begin
      n_fail++;
      $display("FAIL write_issue: wren=%0b rden=%0b wraddr=%h, required 1 0 %h",
               mem_wren, mem_rden, mem_wraddr0, addr);
    end
    send(1'b0, addr, '0, 4'd3, acc);
    n_checks++;
    if (mem_rden !== 1'b1 || mem_wren !== 1'b0 || mem_rdaddr0 !== addr) begin
      n_fail++;
      $display("FAIL read_issue: rden=%0b wren=%0b rdaddr=%h, required 1 0 %h",
               mem_rden, mem_wren, mem_rdaddr0, addr);
    end
    wait_resp(acc, LAT + 1, "write_read_latency");
    drain();
  endtask

  task automatic test_stall();
    int    acc;
    addr_t addr;
    addr = 39'h0_0000_0340;
    bus.resp_ready = 1'b1;
    send(1'b0, addr, '0, 4'd9, acc);
    mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (mem_rden !== 1'b1 || mem_rdaddr0 !== addr || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: rden=%0b rdaddr=%h req_ready=%0b, required 1 %h 0",
                 i, mem_rden, mem_rdaddr0, bus.req_ready, addr);
      end
      @(posedge clk); #1;
    end
    mem_stall = 1'b0;
    wait_resp(acc, LAT + 1 + 5, "stall_latency");
    drain();
  endtask

  task automatic test_full_and_pop_accept();
    int   acc;
    exp_t e;
    bus.resp_ready = 1'b0;
    for (int t = 0; t < DEPTH; t++) begin
      send(1'b0, 39'h0_0000_1000 + addr_t'(t * 16), '0, TAG_W'(t), acc);
    end
    // 17th read must wait, even after every read has come back.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 39'h0_0000_3000;
    bus.req_tag   = 4'd14;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_read_block: req_ready=%0b, required 0", bus.req_ready);
    end
    repeat (LAT + 8) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_after_return: req_ready=%0b resp_valid=%0b, required 0 1",
               bus.req_ready, bus.resp_valid);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    send(1'b1, 39'h0_0000_2000, mkline(7), 4'd0, acc);
    n_checks++;
    if (acc < 0) begin
      n_fail++;
      $display("FAIL full_write_accept: accept edge %0d, required a write accept", acc);
    end
    // Pop and read accept on the same edge at full credits.
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr   = 39'h0_0000_3000;
    bus.req_tag    = 4'd10;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pop_accept_ready: req_ready=%0b, required 1", bus.req_ready);
    end else begin
      e.tag  = 4'd10;
      e.data = expect_read(39'h0_0000_3000);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_accept_credits: req_ready=%0b, required 0 (credits still full)", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (LAT + 8) @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_err();
    force_ret = 1'b1;
    @(posedge clk); #1;
    force_ret = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_set: err=%0b resp_valid=%0b, required 1 0", err, bus.resp_valid);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || bus.resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_sticky: err=%0b resp_valid=%0b, required 1 0", err, bus.resp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_inflight();
    int acc;
    int seen;
    bus.resp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      send(1'b0, 39'h0_0000_4000 + addr_t'(t * 16), '0, TAG_W'(t), acc);
    end
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_rden !== 1'b0 || mem_wren !== 1'b0 || mem_rdaddr0 !== '0 ||
        mem_wraddr0 !== '0 || mem_wrdata !== '0 || bus.resp_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: rden=%0b wren=%0b rdaddr=%h resp_valid=%0b err=%0b, required all 0",
               mem_rden, mem_wren, mem_rdaddr0, bus.resp_valid, err);
    end
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1 || err === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midreset_no_resp: %0d cycles with resp_valid or err, required 0", seen);
    end
    @(posedge clk); #1;
    send(1'b0, 39'h0_0000_0100, '0, 4'd7, acc);
    wait_resp(acc, LAT + 1, "post_reset_latency");
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_write_read();
    test_stall();
    test_full_and_pop_accept();
    test_err();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
